// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging host frames onto the 8-bit register bus (burst R/W, address auto-increment).
// Optional write protection of addresses <= RO_LIMIT when SPI_BRIDGE_WR_PROTECT_EN is defined.
`timescale 1ns/1ps
module spi_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RO_LIMIT    = 8'h27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wdata,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD_FETCH,
    S_RD_LOAD,
    S_RD_DATA,
    S_WR_DATA
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
  logic [7:0] rx_byte;
  logic [6:0] addr_q, addr_d;
  logic       miso_q, miso_d;
  logic       wr_en_q, wr_en_d;
  logic       adv_q, adv_d;
  logic       err_q, err_d;
  logic       wr_block;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

`ifdef SPI_BRIDGE_WR_PROTECT_EN
  assign wr_block = ({1'b0, addr_q} <= RO_LIMIT);
`else
  logic unused_ro_limit;
  assign wr_block        = 1'b0;
  assign unused_ro_limit = ^RO_LIMIT;
`endif

  // cs_n sync resets low so a frame already running at reset release never looks like a fresh cs_n fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      adv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_en_q     <= wr_en_d;
      adv_q       <= adv_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    miso_d   = miso_q;
    wr_en_d  = 1'b0;
    adv_d    = 1'b0;
    err_d    = 1'b0;
    rx_byte  = {rx_q[6:0], mosi_s};

    // Write address advances one cycle after the strobe so the strobe carries the current address
    if (adv_q) addr_d = addr_q + 7'd1;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d  = S_CMD;
          bitcnt_d = '0;
          rx_d     = '0;
          tx_d     = '0;
          miso_d   = 1'b0;
        end
      end
      S_RD_FETCH: state_d = S_RD_LOAD;
      S_RD_LOAD: begin
        tx_d    = reg_rdata;
        state_d = S_RD_DATA;
      end
      default: ;
    endcase

    if (state_q != S_IDLE) begin
      if (sclk_rise) begin
        rx_d     = rx_byte;
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          case (state_q)
            S_CMD: begin
              addr_d  = rx_byte[6:0];
              state_d = rx_byte[7] ? S_RD_FETCH : S_WR_DATA;
            end
            S_WR_DATA: begin
              wdata_d = rx_byte;
              adv_d   = 1'b1;
              if (wr_block) err_d = 1'b1;
              else          wr_en_d = 1'b1;
            end
            S_RD_DATA: begin
              addr_d  = addr_q + 7'd1;
              state_d = S_RD_FETCH;
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (cs_rise) begin
        state_d  = S_IDLE;
        bitcnt_d = '0;
        tx_d     = '0;
        miso_d   = 1'b0;
        wr_en_d  = 1'b0;
        adv_d    = 1'b0;
        err_d    = (bitcnt_q != 3'd0);
      end
    end
  end

  assign spi_miso    = miso_q;
  assign busy        = (state_q != S_IDLE);
  assign spi_miso_oe = busy;
  assign reg_addr    = {1'b0, addr_q};
  assign reg_wr_en   = wr_en_q;
  assign reg_wdata   = wdata_q;
  assign reg_rd_en   = (state_q == S_RD_FETCH);
  assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: SPI master stimulus, register-file responder, event and MISO monitors.
`timescale 1ns/1ps
module tb_spi_reg_bridge;

  localparam logic [7:0] RO_LIM = 8'h27;
  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, reg_wr_en, reg_rd_en, busy, frame_err;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  spi_reg_bridge #(.SYNC_STAGES(2), .RO_LIMIT(RO_LIM)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  typedef struct { int kind; logic [7:0] addr; logic [7:0] data; } ev_t;
  typedef struct { bit chk; logic [7:0] val; } mb_t;

  ev_t        exp_q[$];
  mb_t        miso_exp_q[$];
  logic [7:0] model_mem [0:127];
  logic [7:0] resp_mem  [0:127];
  logic [7:0] wbuf      [0:7];
  int         errors = 0;
  int         checks = 0;
  int         H = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Register-file responder: read data appears the cycle after reg_rd_en
  always @(posedge clk) begin
    if (rst) begin
      reg_rdata <= '0;
      for (int i = 0; i < 128; i++) resp_mem[i] <= model_mem[i];
    end else begin
      if (reg_rd_en) reg_rdata <= resp_mem[reg_addr[6:0]];
      if (reg_wr_en) resp_mem[reg_addr[6:0]] <= reg_wdata;
    end
  end

  task automatic pop_cmp(input int k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h data 0x%0h, required none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (e.kind == k && k != K_ERR) check("event_addr", a, e.addr);
      if (e.kind == k && k == K_WR) check("event_wdata", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en || reg_rd_en) check("strobe_exclusive", reg_wr_en & reg_rd_en, 0);
      if (reg_wr_en) pop_cmp(K_WR, reg_addr, reg_wdata);
      if (reg_rd_en) pop_cmp(K_RD, reg_addr, 8'h00);
      if (frame_err) pop_cmp(K_ERR, 8'h00, 8'h00);
    end
  end

  int         mcnt = 0;
  logic [7:0] msh  = '0;
  always @(posedge spi_sclk or posedge spi_cs_n) begin : miso_mon
    mb_t m;
    if (spi_cs_n) begin
      mcnt = 0;
    end else begin
      msh = {msh[6:0], spi_miso};
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        if (miso_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_miso_byte: got 0x%0h, required none", msh);
        end else begin
          m = miso_exp_q.pop_front();
          if (m.chk) check("miso_byte", msh, m.val);
        end
      end
    end
  end

  task automatic push_ev(input int k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_miso(input bit chk, input logic [7:0] v);
    mb_t m;
    m.chk = chk; m.val = v;
    miso_exp_q.push_back(m);
  endtask

  function automatic bit wr_blocked(input logic [6:0] a);
`ifdef SPI_BRIDGE_WR_PROTECT_EN
    return ({1'b0, a} <= RO_LIM);
`else
    return (a > 7'h7F);
`endif
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = v[7-i];
      wait_clks(H);
      spi_sclk = 1'b1;
      wait_clks(H);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(H);
    check("busy_in_frame", {busy, spi_miso_oe}, 2'b11);
  endtask

  task automatic cs_high();
    wait_clks(H);
    spi_cs_n = 1'b1;
    wait_clks(2 * H);
    check("idle_after_frame", {busy, spi_miso_oe, spi_miso}, 3'b000);
  endtask

  // Reference: one read per byte boundary (first after cmd), one write per data byte, wrap mod 128
  task automatic frame(input bit rnw, input logic [6:0] a, input int n, input int pbits);
    logic [6:0] ai, nxt;
    logic [7:0] b;
    cs_low();
    push_miso(1'b1, 8'h00);
    if (rnw) push_ev(K_RD, {1'b0, a}, 8'h00);
    spi_bits({rnw, a}, 8);
    for (int i = 0; i < n; i++) begin
      ai = a + 7'(i);
      if (rnw) begin
        nxt = ai + 7'd1;
        push_miso(1'b1, model_mem[ai]);
        push_ev(K_RD, {1'b0, nxt}, 8'h00);
        b = 8'($urandom);
      end else begin
        b = wbuf[i];
        push_miso(1'b0, 8'h00);
        if (wr_blocked(ai)) begin
          push_ev(K_ERR, 8'h00, 8'h00);
        end else begin
          push_ev(K_WR, {1'b0, ai}, b);
          model_mem[ai] = b;
        end
      end
      spi_bits(b, 8);
    end
    if (pbits > 0) begin
      push_ev(K_ERR, 8'h00, 8'h00);
      spi_bits(8'($urandom), pbits);
    end
    cs_high();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) model_mem[i] = 8'($urandom);
    model_mem[0] = 8'h00; model_mem[1] = 8'h00; model_mem[2] = 8'hC0; model_mem[3] = 8'h7F;

    rst = 1'b1;
    wait_clks(5);
    check("reset_outputs", {spi_miso, spi_miso_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy, frame_err}, 0);
    rst = 1'b0;
    wait_clks(10);

    wbuf[0] = 8'hA5;
    frame(1'b0, 7'h29, 1, 0);
    frame(1'b1, 7'h00, 4, 0);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    frame(1'b0, 7'h7F, 2, 0);
    frame(1'b1, 7'h7E, 3, 0);

    wbuf[0] = 8'h3C;
    frame(1'b0, 7'h40, 0, 5);
    frame(1'b0, 7'h40, 1, 0);
    frame(1'b1, 7'h40, 1, 3);

    cs_low();
    push_ev(K_ERR, 8'h00, 8'h00);
    spi_bits(8'h85, 3);
    cs_high();
    cs_low();
    cs_high();

    wbuf[0] = 8'h55;
    frame(1'b0, 7'h10, 1, 0);
    wbuf[0] = 8'h66; wbuf[1] = 8'h77;
    frame(1'b0, 7'h27, 2, 0);

    // Reset mid-byte: the interrupted frame must produce nothing until cs_n cycles
    cs_low();
    push_miso(1'b0, 8'h00);
    spi_bits(8'h29, 8);
    push_miso(1'b0, 8'h00);
    spi_bits(8'hFF, 3);
    rst = 1'b1;
    wait_clks(3);
    check("reset_mid_frame", {spi_miso, spi_miso_oe, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, busy, frame_err}, 0);
    rst = 1'b0;
    wait_clks(2);
    spi_bits(8'hFF, 5);
    push_miso(1'b0, 8'h00);
    spi_bits(8'h12, 8);
    check("busy_after_rst", {busy, spi_miso_oe}, 2'b00);
    cs_high();
    wbuf[0] = 8'h5A;
    frame(1'b0, 7'h29, 1, 0);
    frame(1'b1, 7'h29, 1, 0);

    for (int f = 0; f < 25; f++) begin
      bit         rnw;
      logic [6:0] a;
      int         n, pb;
      H   = $urandom_range(8, 12);
      rnw = 1'($urandom_range(0, 1));
      a   = 7'($urandom);
      n   = $urandom_range(0, 4);
      pb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      frame(rnw, a, n, pb);
    end

    wait_clks(20);
    check("events_drained", exp_q.size(), 0);
    check("miso_drained", miso_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
